// File: rtl/toggle_dec_pkg.sv
// Shared types and default parameters for the toggle event decoder.
package toggle_dec_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SYNC_STAGES_D = 2;
    localparam int PEND_W_D      = 4;
    localparam int CNT_W_D       = 16;

endpackage

// File: rtl/toggle_event_decoder_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw level through STAGES flops; only the last one is used downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Recovers events from a toggle line: synchronize, detect transitions,
// strobe one pulse per event, and buffer events as credits for a consumer.
module toggle_event_decoder
    import toggle_dec_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_D,
    parameter int PEND_W      = PEND_W_D,
    parameter int CNT_W       = CNT_W_D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tog_in,
    input  logic              clr,
    output logic              evt_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overflow,
    output logic              busy_init
);

    localparam int                INIT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

    state_t              state;
    state_t              state_nxt;
    logic [INIT_W-1:0]   init_cnt;
    logic                sync_out;
    logic                prev;
    logic                run;
    logic                edge_det;
    logic                accept;
    logic                full;
    logic                drop;
    logic [PEND_W-1:0]   pend_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (tog_in),
        .q     (sync_out)
    );

    // State register plus the INIT dwell counter that lets the synchronizer settle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT && init_cnt != INIT_LAST) begin
                init_cnt <= init_cnt + INIT_W'(1);
            end
        end
    end

    // Leave INIT on its last edge; RUN is terminal until reset
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_cnt == INIT_LAST) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy_init = (state == INIT);
        run       = (state == RUN);
    end

    // Track the last synchronized level; in INIT this silently sets the baseline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= sync_out;
        end
    end

    assign edge_det  = run && (sync_out != prev);
    assign evt_valid = (pending != '0);
    assign accept    = evt_valid && evt_ready;
    assign full      = (pending == {PEND_W{1'b1}});
    assign drop      = edge_det && !accept && full;

    // Credit arithmetic: an edge and an accept in the same cycle cancel out
    always_comb begin
        pend_nxt = pending;
        if (edge_det && !accept && !full) begin
            pend_nxt = pending + PEND_W'(1);
        end else if (!edge_det && accept) begin
            pend_nxt = pending - PEND_W'(1);
        end
    end

    // Event strobe, credit register, running total and sticky overflow (set beats clr)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_pulse <= 1'b0;
            pending   <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            evt_pulse <= edge_det;
            pending   <= pend_nxt;
            if (clr) begin
                evt_count <= edge_det ? CNT_W'(1) : '0;
            end else if (edge_det) begin
                evt_count <= evt_count + CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Scoreboard bench for toggle_event_decoder (SYNC_STAGES=2, PEND_W=2, CNT_W=4).
module tb_toggle_event_decoder;

    localparam int SS = 2;
    localparam int PW = 2;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          tog_in;
    logic          clr;
    logic          evt_pulse;
    logic          evt_valid;
    logic          evt_ready;
    logic [PW-1:0] pending;
    logic [CW-1:0] evt_count;
    logic          overflow;
    logic          busy_init;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int            cyc;
        logic [CW-1:0] cnt;
        logic [PW-1:0] pend;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    toggle_event_decoder #(
        .SYNC_STAGES (SS),
        .PEND_W      (PW),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tog_in    (tog_in),
        .clr       (clr),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .pending   (pending),
        .evt_count (evt_count),
        .overflow  (overflow),
        .busy_init (busy_init)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse pops one expected event and checks its timing and side effects
    always @(negedge clk) begin
        if (evt_pulse === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: pulse seen at cycle %0d, none expected", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL pulse_latency: got cycle %0d, expected %0d", cyc, mon_e.cyc);
                end
                checks++;
                if (evt_count !== mon_e.cnt) begin
                    errors++;
                    $display("FAIL pulse_count: got %0d, expected %0d", evt_count, mon_e.cnt);
                end
                checks++;
                if (pending !== mon_e.pend) begin
                    errors++;
                    $display("FAIL pulse_pending: got %0d, expected %0d", pending, mon_e.pend);
                end
                checks++;
                if (overflow !== mon_e.ovf) begin
                    errors++;
                    $display("FAIL pulse_overflow: got %0b, expected %0b", overflow, mon_e.ovf);
                end
            end
        end
    end

    task automatic toggle_once(input logic [CW-1:0] ecnt, input logic [PW-1:0] epend,
                               input logic eovf, input logic rdy_at_pulse, input logic clr_at_pulse);
        exp_t e;
        @(negedge clk);
        tog_in = ~tog_in;
        e.cyc  = cyc + SS + 1;
        e.cnt  = ecnt;
        e.pend = epend;
        e.ovf  = eovf;
        sb.push_back(e);
        repeat (2) @(negedge clk);
        if (rdy_at_pulse) evt_ready = 1'b1;
        if (clr_at_pulse) clr = 1'b1;
        @(negedge clk);
        if (rdy_at_pulse) evt_ready = 1'b0;
        if (clr_at_pulse) clr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d events never pulsed, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        tog_in    = 1'b1;
        clr       = 1'b0;
        evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_init, evt_pulse, evt_valid, overflow, pending, evt_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b pulse=%0b valid=%0b ovf=%0b pend=%0d cnt=%0d, expected 1 0 0 0 0 0",
                     busy_init, evt_pulse, evt_valid, overflow, pending, evt_count);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (busy_init !== (i < SS + 1)) begin
                errors++;
                $display("FAIL busy_init_%0d: got %0b, expected %0b", i, busy_init, (i < SS + 1));
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (pending !== 2'd0 || evt_count !== 4'd0) begin
            errors++;
            $display("FAIL idle_after_init: got pend=%0d cnt=%0d, expected 0 0", pending, evt_count);
        end
    endtask

    task automatic test_single();
        toggle_once(4'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        wait_drain("single");
        checks++;
        if (evt_valid !== 1'b1 || pending !== 2'd1) begin
            errors++;
            $display("FAIL single_valid: got valid=%0b pend=%0d, expected 1 1", evt_valid, pending);
        end
        @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || pending !== 2'd0) begin
            errors++;
            $display("FAIL single_accept: got valid=%0b pend=%0d, expected 0 0", evt_valid, pending);
        end
        evt_ready = 1'b1;
        repeat (2) @(negedge clk);
        evt_ready = 1'b0;
        checks++;
        if (pending !== 2'd0) begin
            errors++;
            $display("FAIL ready_when_empty: got pend=%0d, expected 0", pending);
        end
    endtask

    task automatic test_fill();
        pulse_clr();
        checks++;
        if (evt_count !== 4'd0) begin
            errors++;
            $display("FAIL fill_preclear: got cnt=%0d, expected 0", evt_count);
        end
        toggle_once(4'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        toggle_once(4'd2, 2'd2, 1'b0, 1'b0, 1'b0);
        toggle_once(4'd3, 2'd3, 1'b0, 1'b0, 1'b0);
        toggle_once(4'd4, 2'd3, 1'b1, 1'b0, 1'b0);
        wait_drain("fill");
        checks++;
        if (pending !== 2'd3 || evt_count !== 4'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got pend=%0d cnt=%0d ovf=%0b, expected 3 4 1", pending, evt_count, overflow);
        end
        pulse_clr();
        checks++;
        if (pending !== 2'd3 || evt_count !== 4'd0 || overflow !== 1'b0 || evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_clr: got pend=%0d cnt=%0d ovf=%0b valid=%0b, expected 3 0 0 1",
                     pending, evt_count, overflow, evt_valid);
        end
    endtask

    task automatic test_simultaneous();
        toggle_once(4'd1, 2'd3, 1'b0, 1'b1, 1'b0);
        wait_drain("simul");
        checks++;
        if (pending !== 2'd3 || evt_count !== 4'd1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_edge_accept: got pend=%0d cnt=%0d ovf=%0b, expected 3 1 0", pending, evt_count, overflow);
        end
        toggle_once(4'd1, 2'd3, 1'b1, 1'b0, 1'b1);
        wait_drain("clr_ovf");
        checks++;
        if (evt_count !== 4'd1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_overflow: got cnt=%0d ovf=%0b, expected 1 1", evt_count, overflow);
        end
        @(negedge clk);
        evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        evt_ready = 1'b0;
        checks++;
        if (pending !== 2'd0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: got pend=%0d valid=%0b, expected 0 0", pending, evt_valid);
        end
        pulse_clr();
    endtask

    task automatic test_wrap();
        evt_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            toggle_once(CW'((i + 1) % 16), 2'd1, 1'b0, 1'b0, 1'b0);
        end
        wait_drain("wrap");
        @(negedge clk);
        checks++;
        if (evt_count !== 4'd1 || pending !== 2'd0) begin
            errors++;
            $display("FAIL wrap: got cnt=%0d pend=%0d, expected 1 0", evt_count, pending);
        end
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b1;
        toggle_once(4'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        toggle_once(4'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        wait_drain("premid_a");
        @(negedge clk);
        evt_ready = 1'b0;
        toggle_once(4'd4, 2'd1, 1'b0, 1'b0, 1'b0);
        toggle_once(4'd5, 2'd2, 1'b0, 1'b0, 1'b0);
        wait_drain("premid_b");
        checks++;
        if (pending !== 2'd2 || evt_count !== 4'd5) begin
            errors++;
            $display("FAIL premid_state: got pend=%0d cnt=%0d, expected 2 5", pending, evt_count);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy_init, evt_pulse, evt_valid, overflow, pending, evt_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0}) begin
            errors++;
            $display("FAIL async_reset: got busy=%0b pulse=%0b valid=%0b ovf=%0b pend=%0d cnt=%0d, expected 1 0 0 0 0 0",
                     busy_init, evt_pulse, evt_valid, overflow, pending, evt_count);
        end
        tog_in = ~tog_in;
        @(negedge clk);
        reset  = 1'b0;
        tog_in = ~tog_in;
        repeat (8) @(negedge clk);
        checks++;
        if (busy_init !== 1'b0 || evt_count !== 4'd0 || pending !== 2'd0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reinit_baseline: got busy=%0b cnt=%0d pend=%0d valid=%0b, expected 0 0 0 0",
                     busy_init, evt_count, pending, evt_valid);
        end
        toggle_once(4'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        wait_drain("post_reset");
        checks++;
        if (evt_count !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_event: got cnt=%0d, expected 1", evt_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
Receive-side counterpart of the team's T flip-flop toggle encoder. A sender flips a single level line once per event, and this block recovers those events. It synchronizes the line into the local clock domain, detects each transition, and emits a one-cycle pulse per event. It also buffers un-consumed events as a credit count behind a valid/ready handshake, and keeps a running event total and a sticky overflow flag.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on tog_in (legal 2..4)
PEND_W, 4, width of pending-event counter; max pending = 2^PEND_W-1
CNT_W, 16, width of total event counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
tog_in  input  1  toggle line from sender, asynchronous to clk
clr  input  1  synchronous clear of evt_count and overflow
evt_pulse  output  1  one-cycle strobe per detected toggle
evt_valid  output  1  at least one pending event
evt_ready  input  1  consumer accepts one event when evt_valid
pending  output  PEND_W  number of buffered events
evt_count  output  CNT_W  total events detected, modulo 2^CNT_W
overflow  output  1  sticky: an event was dropped because pending was full
busy_init  output  1  high while in INIT state

Behaviour:
- Reset:
  - Asserting reset clears all flops immediately, regardless of clk.
  - Reset values: sync chain 0, prev 0, state INIT, init counter 0, evt_pulse 0, pending 0, evt_valid 0, evt_count 0, overflow 0, busy_init 1.
- FSM states:
  - INIT:
    - Lasts SYNC_STAGES+1 rising edges after reset deasserts.
    - prev <= sync_out every cycle; no events are generated.
    - Toggles arriving during INIT are absorbed as baseline and are not counted.
    - Exits to RUN on the last INIT edge.
  - RUN:
    - edge = (sync_out != prev); prev <= sync_out every cycle.
    - Stays in RUN until reset.
- Latency:
  - A tog_in change sampled at edge k gives evt_pulse high for exactly one cycle after edge k+SYNC_STAGES.
  - pending increments on that same edge k+SYNC_STAGES.
  - Rising and falling transitions count equally.
- Handshake:
  - evt_valid = (pending != 0), registered-equivalent (derived from the pending register only).
  - accept = evt_valid && evt_ready; an accept decrements pending by 1.
  - evt_ready while evt_valid=0 has no effect.
- Pending update per edge:
  - edge only: +1.
  - accept only: -1.
  - edge and accept together: pending unchanged.
  - edge while pending is full and no accept: pending stays full, overflow <= 1, evt_count still increments, evt_pulse still fires.
  - edge and accept together while full: no overflow.
- evt_count: +1 per edge in RUN; wraps from 2^CNT_W-1 to 0 with no flag.
- clr:
  - Sets evt_count to 0 and overflow to 0 on the next edge.
  - If an edge occurs in the same cycle, evt_count = 1.
  - If an overflowing edge occurs in the same cycle, overflow = 1 (set wins).
  - pending is not affected by clr.
- Reset mid-operation: all pending events are discarded, and the FSM returns to INIT to re-baseline.
- Input constraint (documented, not checked): the sender toggles no more often than once every SYNC_STAGES+1 clk cycles. Faster toggles may merge.

Decomposition:
- Package toggle_dec_pkg holds:
  - enum state_t {INIT, RUN};
  - default constants SYNC_STAGES_D=2, PEND_W_D=4, CNT_W_D=16.
- Sub-module sync_chain (param STAGES): an async-reset flop chain producing sync_out.
- Top level holds the FSM, edge detect, pending/credit counter and total counter.

Test Plan:
- Reset then idle, tog_in=1 held from time 0:
  - busy_init is high for 3 cycles, then 0.
  - No evt_pulse occurs; pending=0, evt_count=0.
- Single toggle in RUN, SYNC_STAGES=2:
  - tog_in 0->1 sampled at edge k.
  - evt_pulse is high for one cycle after edge k+2; pending=1, evt_valid=1, evt_count=1.
  - Pulse evt_ready for 1 cycle: pending=0, evt_valid=0.
- Fill buffer, PEND_W=2, evt_ready=0:
  - Apply 4 toggles spaced 4 cycles apart.
  - pending=3, evt_count=4, overflow=1.
  - Assert clr: overflow=0, evt_count=0, pending=3.
- Simultaneous edge and accept at pending=3, PEND_W=2:
  - pending stays 3, overflow stays 0, evt_count increments by 1.
- Counter wrap, CNT_W=4:
  - Drive 17 toggles with evt_ready=1.
  - evt_count=1 and pending=0 after the last event drains.
- Reset mid-operation:
  - With pending=2 and evt_count=5, assert reset asynchronously, between clock edges.
  - All outputs go to their reset values immediately.
  - After release, INIT runs again and a toggle that occurred during INIT is not counted.
